pe_vec_mac_acc: RTL and testbench
=================================

# pe_vec_mac_acc

Parametrised vector multiply-accumulate processing element for the DSP-mapped systolic array: the next generation of the six-lane PE, with a generic lane count, signed widened arithmetic, a valid-qualified three-stage DSP-friendly pipeline and an output-stationary accumulate mode with drain. The block sits in the array grid. It forwards `a`/`b` to its neighbours one cycle later, and emits partial sums (stream mode) or drained accumulators (accumulate mode) toward the array edge.

## Interface
- `DATA_W`, 16: operand, `c_in` and `c_out` width, signed two's complement.
- `VECTOR`, 6: number of lanes; must be ≥1.
- `ACC_W`, 40: internal accumulator width; must be ≥2*`DATA_W`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  beat qualifier for `a_in`/`b_in`/`c_in`/`mode`/`acc_clr`.
- `mode`  in  1  per-beat mode: 0 = stream (`a*b+c`), 1 = accumulate.
- `acc_clr`  in  1  per-beat control, mode 1 only: this beat starts a fresh accumulation.
- `drain`  in  1  per-beat control, mode 1 only: emit the accumulator including this beat; accepted with or without `in_valid`.
- `a_in`  in  VECTOR x DATA_W  per-lane operand.
- `b_in`  in  DATA_W  scalar operand broadcast to all lanes.
- `c_in`  in  VECTOR x DATA_W  per-lane partial sum from the upstream PE.
- `a_out`  out  VECTOR x DATA_W  `a_in` forwarded.
- `b_out`  out  DATA_W  `b_in` forwarded.
- `fwd_valid`  out  1  qualifies `a_out`/`b_out`.
- `c_out`  out  VECTOR x DATA_W  per-lane saturated result.
- `out_valid`  out  1  qualifies `c_out`.
- `ovf`  out  VECTOR  sticky per-lane saturation flags.

## Operation
- Each beat is a token carrying {valid, mode, acc_clr, drain, operands}. Tokens advance one stage per cycle. There is no backpressure.
- S1 registers the operands, the token, and the forward path (`a_out`, `b_out`, `fwd_valid` = S1 state).
- S2 registers the full-precision signed product `a[i]*b` (2*DATA_W bits) and `c[i]`.
- S3 performs the add or accumulate, registers `c_out`, and updates `acc[i]`.
- Mode 0 valid beat: `c_out[i] = sat_DATA_W(sext(prod)+sext(c))`; `out_valid`=1; `acc` is untouched.
- Mode 1 valid beat: the base is 0 if `acc_clr`, else `acc[i]`. The new value is `sat_ACC_W(base+prod)`; `c_in` is ignored.
- If the mode-1 token carries `drain`:
  - `c_out[i] = sat_DATA_W(new)`, `out_valid`=1, and `acc[i]` is cleared to 0.
  - Otherwise `acc[i]` = new and `out_valid`=0.
- A `drain` without `in_valid` uses prod = 0; `mode` is taken as 1.
- `acc_clr` and `drain` on the same beat: the output is the saturated product alone; `acc` ends at 0.
- Mode-0 and mode-1 beats may interleave freely. Only mode-1 beats touch `acc`.
- Saturation clamps to [−2^(W−1), 2^(W−1)−1]. Any clamp at ACC_W or DATA_W sets `ovf[i]`.
- `ovf[i]` clears only on reset or when a mode-1 `acc_clr` token reaches S3. On that same cycle it takes that beat's clamp result.
- When `out_valid`=0, `c_out` holds its last value.

## Timing
- Reset (async assert, sync release edge irrelevant): all pipeline registers, `acc`, `a_out`, `b_out`, `c_out` are 0. `fwd_valid`, `out_valid` and `ovf` are 0. All in-flight tokens are dropped.
- Forward latency is 1 cycle: a beat at edge t appears on `a_out`/`b_out` with `fwd_valid` after edge t.
- Result latency is 3 cycles: a beat sampled at edge t gives `out_valid` after edge t+2.
- Throughput is one beat per cycle, back-to-back, in any mode mix.
- Reset mid-accumulation: the accumulator is lost and no drain output is produced. The first post-reset mode-1 beat accumulates from 0 whether or not `acc_clr` is set.
- Cycles with `in_valid`=0 and `drain`=0 are bubbles: no state change except pipeline advance.

## Test plan
- Stream: a=[1..6], b=3, c=[10,20,30,40,50,60], mode 0 -> after 3 cycles `c_out`=[13,26,39,52,65,78], `out_valid` high exactly 1 cycle, `ovf`=0.
- Stream saturation: lane0 a=0x7FFF, b=0x7FFF, c=0 and lane1 a=0x8000, b=0x7FFF, c=0 -> `c_out[0]`=0x7FFF, `c_out[1]`=0x8000, `ovf`=6'b000011 persisting through subsequent mode-0 beats.
- Accumulate: 4 back-to-back mode-1 beats a=2, b=5 all lanes; `acc_clr` on the first, `drain` on the last -> a single `out_valid` with `c_out`=40 all lanes; a following drain-only token outputs 0.
- Interleave: mode-1 beats (a=1, b=7, `acc_clr` first) alternated with mode-0 beats (a=1, b=1, c=100); drain on the 3rd mode-1 beat -> mode-0 outputs are all 101; the drained output is 21.
- Forwarding: random `a_in`/`b_in` with `in_valid` toggling -> `a_out`/`b_out`/`fwd_valid` equal the inputs delayed exactly 1 cycle.
- Reset mid-operation: assert `rst_n`=0 between the 2nd and 3rd of 4 accumulate beats -> all outputs are 0 immediately and asynchronously; no `out_valid` from in-flight tokens. The post-reset beat a=3, b=3 with drain yields 9.

Source files
------------

// File: rtl/pe_vec_mac_acc.sv
// Vector MAC processing element: per-lane signed a*b, broadcast b, three-stage pipeline,
// stream (a*b+c) or output-stationary accumulate with drain, sticky per-lane saturation flags.
module pe_vec_mac_acc #(
  parameter int DATA_W = 16,
  parameter int VECTOR = 6,
  parameter int ACC_W  = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           mode,
  input  logic                           acc_clr,
  input  logic                           drain,
  input  logic [VECTOR-1:0][DATA_W-1:0]  a_in,
  input  logic [DATA_W-1:0]              b_in,
  input  logic [VECTOR-1:0][DATA_W-1:0]  c_in,
  output logic [VECTOR-1:0][DATA_W-1:0]  a_out,
  output logic [DATA_W-1:0]              b_out,
  output logic                           fwd_valid,
  output logic [VECTOR-1:0][DATA_W-1:0]  c_out,
  output logic                           out_valid,
  output logic [VECTOR-1:0]              ovf
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = ACC_W + 1;

  // Returns {clamped, value} after narrowing an SW-bit sum to ACC_W bits.
  function automatic logic [ACC_W:0] sat_acc(input logic signed [SW-1:0] x);
    if (x[SW-1] != x[SW-2]) sat_acc = {1'b1, x[SW-1], {(ACC_W-1){~x[SW-1]}}};
    else                    sat_acc = {1'b0, x[ACC_W-1:0]};
  endfunction

  // Returns {clamped, value} after narrowing an SW-bit value to DATA_W bits.
  function automatic logic [DATA_W:0] sat_data(input logic signed [SW-1:0] x);
    logic [SW-DATA_W:0] top;
    top = x[SW-1:DATA_W-1];
    if (&top || ~|top) sat_data = {1'b0, x[DATA_W-1:0]};
    else               sat_data = {1'b1, x[SW-1], {(DATA_W-1){~x[SW-1]}}};
  endfunction

  logic                          vld_p0_q, vld_p0_d, op_p0_q, op_p0_d;
  logic                          mode_p0_q, mode_p0_d, clr_p0_q, clr_p0_d, drn_p0_q, drn_p0_d;
  logic [VECTOR-1:0][DATA_W-1:0] a_p0_q, a_p0_d, c_p0_q, c_p0_d;
  logic [DATA_W-1:0]             b_p0_q, b_p0_d;

  logic                          vld_p1_q, vld_p1_d, mode_p1_q, mode_p1_d;
  logic                          clr_p1_q, clr_p1_d, drn_p1_q, drn_p1_d;
  logic [VECTOR-1:0][PW-1:0]     prod_p1_q, prod_p1_d;
  logic [VECTOR-1:0][DATA_W-1:0] c_p1_q, c_p1_d;

  logic                          out_valid_q, out_valid_d;
  logic [VECTOR-1:0][DATA_W-1:0] cout_q, cout_d;
  logic [VECTOR-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic [VECTOR-1:0]             ovf_q, ovf_d;

  always_comb begin
    logic signed [SW-1:0] prod_x, base, sum;
    logic [ACC_W:0]       sa;
    logic [DATA_W:0]      sd;
    logic                 flag;

    // Stage 1: token capture; a drain without a beat behaves as an accumulate token.
    vld_p0_d  = in_valid | drain;
    op_p0_d   = in_valid;
    mode_p0_d = in_valid ? mode : 1'b1;
    clr_p0_d  = in_valid & mode & acc_clr;
    drn_p0_d  = drain & (~in_valid | mode);
    a_p0_d    = a_in;
    b_p0_d    = b_in;
    c_p0_d    = c_in;

    // Stage 2: full-precision product, forced to zero for drain-only tokens.
    vld_p1_d  = vld_p0_q;
    mode_p1_d = mode_p0_q;
    clr_p1_d  = clr_p0_q;
    drn_p1_d  = drn_p0_q;
    c_p1_d    = c_p0_q;
    for (int i = 0; i < VECTOR; i++) begin
      prod_p1_d[i] = op_p0_q ? PW'($signed(a_p0_q[i])) * PW'($signed(b_p0_q)) : '0;
    end

    // Stage 3: add or accumulate, saturate, drain.
    out_valid_d = vld_p1_q & (~mode_p1_q | drn_p1_q);
    cout_d      = cout_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    for (int i = 0; i < VECTOR; i++) begin
      prod_x = SW'($signed(prod_p1_q[i]));
      base   = '0;
      sum    = '0;
      sa     = '0;
      sd     = '0;
      flag   = 1'b0;
      if (vld_p1_q && !mode_p1_q) begin
        sum       = prod_x + SW'($signed(c_p1_q[i]));
        sd        = sat_data(sum);
        cout_d[i] = sd[DATA_W-1:0];
        ovf_d[i]  = ovf_q[i] | sd[DATA_W];
      end else if (vld_p1_q) begin
        base = clr_p1_q ? '0 : SW'($signed(acc_q[i]));
        sa   = sat_acc(prod_x + base);
        flag = sa[ACC_W];
        if (drn_p1_q) begin
          sd        = sat_data(SW'($signed(sa[ACC_W-1:0])));
          cout_d[i] = sd[DATA_W-1:0];
          flag      = flag | sd[DATA_W];
          acc_d[i]  = '0;
        end else begin
          acc_d[i]  = sa[ACC_W-1:0];
        end
        ovf_d[i] = (ovf_q[i] & ~clr_p1_q) | flag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q    <= 1'b0;
      op_p0_q     <= 1'b0;
      mode_p0_q   <= 1'b0;
      clr_p0_q    <= 1'b0;
      drn_p0_q    <= 1'b0;
      a_p0_q      <= '0;
      b_p0_q      <= '0;
      c_p0_q      <= '0;
      vld_p1_q    <= 1'b0;
      mode_p1_q   <= 1'b0;
      clr_p1_q    <= 1'b0;
      drn_p1_q    <= 1'b0;
      prod_p1_q   <= '0;
      c_p1_q      <= '0;
      out_valid_q <= 1'b0;
      cout_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= '0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      op_p0_q     <= op_p0_d;
      mode_p0_q   <= mode_p0_d;
      clr_p0_q    <= clr_p0_d;
      drn_p0_q    <= drn_p0_d;
      a_p0_q      <= a_p0_d;
      b_p0_q      <= b_p0_d;
      c_p0_q      <= c_p0_d;
      vld_p1_q    <= vld_p1_d;
      mode_p1_q   <= mode_p1_d;
      clr_p1_q    <= clr_p1_d;
      drn_p1_q    <= drn_p1_d;
      prod_p1_q   <= prod_p1_d;
      c_p1_q      <= c_p1_d;
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign a_out     = a_p0_q;
  assign b_out     = b_p0_q;
  assign fwd_valid = op_p0_q;
  assign c_out     = cout_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_vec_mac_acc.sv
// Bench for pe_vec_mac_acc: directed vector table, reset sequence, ACC-width overflow run
// and randomized beats checked against an integer reference model.
module tb_pe_vec_mac_acc;

  localparam int DW = 16;
  localparam int NV = 6;
  localparam int AW = 40;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0, mode = 1'b0, acc_clr = 1'b0, drain = 1'b0;
  logic [NV-1:0][DW-1:0] a_in = '0, c_in = '0;
  logic [DW-1:0]         b_in = '0;
  logic [NV-1:0][DW-1:0] a_out, c_out;
  logic [DW-1:0]         b_out;
  logic                  fwd_valid, out_valid;
  logic [NV-1:0]         ovf;

  pe_vec_mac_acc #(.DATA_W(DW), .VECTOR(NV), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
    .drain(drain), .a_in(a_in), .b_in(b_in), .c_in(c_in), .a_out(a_out), .b_out(b_out),
    .fwd_valid(fwd_valid), .c_out(c_out), .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                  iv, md, clr, drn;
    logic [NV-1:0][DW-1:0] a;
    logic [DW-1:0]         b;
    logic [NV-1:0][DW-1:0] c;
    logic                  eov;
    logic [NV-1:0][DW-1:0] ec;
    logic [NV-1:0]         eovf;
  } vec_t;

  typedef struct packed {
    logic                  ov;
    logic                  cmpc;
    logic [NV-1:0][DW-1:0] c;
    logic [NV-1:0]         ovf;
  } exp_t;

  int total = 0;
  int bad = 0;
  vec_t tbl[$];
  exp_t q[$];

  longint                m_acc[NV];
  logic [NV-1:0][DW-1:0] m_cout;
  logic [NV-1:0]         m_ovf;

  function automatic logic [NV*DW-1:0] rep(input logic [DW-1:0] x);
    return {NV{x}};
  endfunction

  function automatic vec_t mk(input logic iv, md, clr, drn, input logic [NV*DW-1:0] a,
                              input logic [DW-1:0] b, input logic [NV*DW-1:0] c,
                              input logic eov, input logic [NV*DW-1:0] ec,
                              input logic [NV-1:0] eovf);
    vec_t v;
    v.iv = iv; v.md = md; v.clr = clr; v.drn = drn;
    v.a = a; v.b = b; v.c = c; v.eov = eov; v.ec = ec; v.eovf = eovf;
    return v;
  endfunction

  function automatic longint sx(input logic [DW-1:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint clampw(input longint v, input int w, output bit f);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    f = 1'b0;
    if (v > mx) begin f = 1'b1; return mx; end
    if (v < mn) begin f = 1'b1; return mn; end
    return v;
  endfunction

  // Reference: each beat is applied in order to lane accumulators held as plain integers.
  function automatic exp_t predict(input vec_t v);
    exp_t   e;
    longint p, s, n;
    bit     f1, f2, clr;
    e.ov = 1'b0;
    e.cmpc = 1'b1;
    if (v.iv && !v.md) begin
      for (int i = 0; i < NV; i++) begin
        p = sx(v.a[i]) * sx(v.b);
        s = clampw(p + sx(v.c[i]), DW, f1);
        m_cout[i] = s[DW-1:0];
        if (f1) m_ovf[i] = 1'b1;
      end
      e.ov = 1'b1;
    end else if (v.iv || v.drn) begin
      clr = v.iv && v.clr;
      for (int i = 0; i < NV; i++) begin
        p = v.iv ? sx(v.a[i]) * sx(v.b) : 0;
        n = clampw((clr ? 0 : m_acc[i]) + p, AW, f1);
        f2 = 1'b0;
        if (v.drn) begin
          s = clampw(n, DW, f2);
          m_cout[i] = s[DW-1:0];
          m_acc[i] = 0;
        end else begin
          m_acc[i] = n;
        end
        m_ovf[i] = (clr ? 1'b0 : m_ovf[i]) | f1 | f2;
      end
      e.ov = v.drn;
    end
    e.c = m_cout;
    e.ovf = m_ovf;
    return e;
  endfunction

  task automatic mreset();
    exp_t idle;
    for (int i = 0; i < NV; i++) m_acc[i] = 0;
    m_cout = '0;
    m_ovf = '0;
    q.delete();
    idle = '{ov: 1'b0, cmpc: 1'b1, c: '0, ovf: '0};
    q.push_back(idle);
    q.push_back(idle);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Drives one beat, advances one edge, checks forwarding and the beat issued two edges earlier.
  task automatic run_beat(input vec_t v, input bit use_tbl);
    exp_t e, f;
    in_valid = v.iv; mode = v.md; acc_clr = v.clr; drain = v.drn;
    a_in = v.a; b_in = v.b; c_in = v.c;
    e = predict(v);
    if (use_tbl) begin
      e.ov = v.eov; e.cmpc = v.eov; e.c = v.ec; e.ovf = v.eovf;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    chk("a_out", a_out, v.a);
    chk("b_out", b_out, v.b);
    chk("fwd_valid", fwd_valid, v.iv);
    f = q.pop_front();
    chk("out_valid", out_valid, f.ov);
    if (f.cmpc) chk("c_out", c_out, f.c);
    chk("ovf", ovf, f.ovf);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) run_beat(mk(0, 0, 0, 0, '0, '0, '0, 0, '0, '0), 1'b0);
  endtask

  initial begin
    vec_t v;
    logic [DW-1:0] ra[NV];

    // Directed vectors: {iv, mode, clr, drain, a, b, c, expected out_valid, c_out, ovf}.
    tbl.push_back(mk(1, 0, 0, 0, {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 16'd3,
                     {16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10},
                     1, {16'd78, 16'd65, 16'd52, 16'd39, 16'd26, 16'd13}, 6'b0));
    tbl.push_back(mk(0, 0, 0, 0, '0, '0, '0, 0, '0, 6'b0));
    tbl.push_back(mk(1, 0, 0, 0, {64'd0, 16'h8000, 16'h7FFF}, 16'h7FFF, '0,
                     1, {64'd0, 16'h8000, 16'h7FFF}, 6'b000011));
    tbl.push_back(mk(1, 0, 0, 0, rep(16'd1), 16'd1, '0, 1, rep(16'd1), 6'b000011));
    tbl.push_back(mk(1, 1, 1, 0, rep(16'd2), 16'd5, rep(16'd7), 0, '0, 6'b0));
    tbl.push_back(mk(1, 1, 0, 0, rep(16'd2), 16'd5, rep(16'd7), 0, '0, 6'b0));
    tbl.push_back(mk(1, 1, 0, 0, rep(16'd2), 16'd5, rep(16'd7), 0, '0, 6'b0));
    tbl.push_back(mk(1, 1, 0, 1, rep(16'd2), 16'd5, rep(16'd7), 1, rep(16'd40), 6'b0));
    tbl.push_back(mk(0, 0, 0, 1, rep(16'd9), 16'd9, rep(16'd9), 1, rep(16'd0), 6'b0));
    tbl.push_back(mk(1, 1, 1, 0, rep(16'd1), 16'd7, rep(16'h1234), 0, '0, 6'b0));
    tbl.push_back(mk(1, 0, 0, 0, rep(16'd1), 16'd1, rep(16'd100), 1, rep(16'd101), 6'b0));
    tbl.push_back(mk(1, 1, 0, 0, rep(16'd1), 16'd7, rep(16'h1234), 0, '0, 6'b0));
    tbl.push_back(mk(1, 0, 0, 0, rep(16'd1), 16'd1, rep(16'd100), 1, rep(16'd101), 6'b0));
    tbl.push_back(mk(1, 1, 0, 1, rep(16'd1), 16'd7, rep(16'h1234), 1, rep(16'd21), 6'b0));
    tbl.push_back(mk(1, 0, 0, 0, rep(16'd1), 16'd1, rep(16'd100), 1, rep(16'd101), 6'b0));
    tbl.push_back(mk(1, 1, 1, 1, rep(16'd4), 16'hFFFD, '0, 1, rep(16'hFFF4), 6'b0));
    tbl.push_back(mk(0, 0, 0, 1, '0, '0, '0, 1, rep(16'd0), 6'b0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst a_out", a_out, '0);
    chk("rst b_out", b_out, '0);
    chk("rst fwd_valid", fwd_valid, 1'b0);
    chk("rst c_out", c_out, '0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst ovf", ovf, '0);
    rst_n = 1'b1;
    mreset();

    for (int k = 0; k < tbl.size(); k++) run_beat(tbl[k], 1'b1);
    bubbles(3);

    // Reset in the middle of an accumulation, with a stream result on the outputs.
    run_beat(mk(1, 0, 0, 0, rep(16'd1), 16'd1, rep(16'd5), 1, rep(16'd6), 6'b0), 1'b1);
    run_beat(mk(1, 1, 1, 0, rep(16'd2), 16'd5, '0, 0, '0, 6'b0), 1'b1);
    run_beat(mk(1, 1, 0, 0, rep(16'd2), 16'd5, '0, 0, '0, 6'b0), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async a_out", a_out, '0);
    chk("async b_out", b_out, '0);
    chk("async fwd_valid", fwd_valid, 1'b0);
    chk("async c_out", c_out, '0);
    chk("async out_valid", out_valid, 1'b0);
    chk("async ovf", ovf, '0);
    in_valid = 1'b0; drain = 1'b0; acc_clr = 1'b0; mode = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mreset();
    bubbles(2);
    run_beat(mk(1, 1, 0, 1, rep(16'd3), 16'd3, '0, 1, rep(16'd9), 6'b0), 1'b1);
    bubbles(3);

    // Drive the accumulator past 2^39 so the ACC-width clamp fires, then drain.
    run_beat(mk(1, 1, 1, 0, rep(16'h8000), 16'h8000, '0, 0, '0, '0), 1'b0);
    for (int k = 0; k < 515; k++)
      run_beat(mk(1, 1, 0, 0, rep(16'h8000), 16'h8000, '0, 0, '0, '0), 1'b0);
    run_beat(mk(0, 0, 0, 1, '0, '0, '0, 0, '0, '0), 1'b0);
    bubbles(3);

    // Randomized beats against the reference model.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NV; i++) begin
        case ($urandom_range(0, 5))
          0:       ra[i] = 16'h7FFF;
          1:       ra[i] = 16'h8000;
          default: ra[i] = 16'($urandom);
        endcase
      end
      v = mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
             $urandom_range(0, 4) == 0, {ra[5], ra[4], ra[3], ra[2], ra[1], ra[0]},
             ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom),
             {6{16'($urandom)}} ^ {NV*DW{1'b0}} ^ {16'($urandom), 80'd0},
             0, '0, '0);
      run_beat(v, 1'b0);
    end
    bubbles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
